// File: rtl/win_if.sv
// Board-to-checker bundle: move strobe and mark masks in, status and sticky result flags out.
interface win_if;
    logic       move_valid;
    logic [8:0] p1_marks;
    logic [8:0] p2_marks;
    logic       busy;
    logic       check_done;
    logic       player1_win;
    logic       player2_win;
    logic       board_error;
    logic       draw;

    modport master (
        output move_valid, p1_marks, p2_marks,
        input  busy, check_done, player1_win, player2_win, board_error, draw
    );

    modport slave (
        input  move_valid, p1_marks, p2_marks,
        output busy, check_done, player1_win, player2_win, board_error, draw
    );
endinterface

// File: rtl/win_checker.sv
// Sequential tic-tac-toe win evaluator: snapshots both masks on move_valid, scans the 8 lines
// LINES_PER_CYCLE at a time, and commits sticky flags. Draw detection enabled by DRAW_DETECT_EN.
module win_checker #(
    parameter int unsigned LINES_PER_CYCLE = 1
) (
    input logic  clk,
    input logic  reset,
    win_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StScan, StOver} state_e;

    // Step wraps to 0 for LINES_PER_CYCLE=8, where the single group is also the last one.
    localparam logic [2:0] Step    = 3'(LINES_PER_CYCLE % 8);
    localparam logic [2:0] LastIdx = 3'(8 - LINES_PER_CYCLE);

    function automatic logic [8:0] line_mask(input logic [2:0] idx);
        logic [8:0] m;
        unique case (idx)
            3'd0: m = 9'h007;
            3'd1: m = 9'h038;
            3'd2: m = 9'h1C0;
            3'd3: m = 9'h049;
            3'd4: m = 9'h092;
            3'd5: m = 9'h124;
            3'd6: m = 9'h111;
            3'd7: m = 9'h054;
        endcase
        return m;
    endfunction

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [8:0] p1_snap_q, p1_snap_d, p2_snap_q, p2_snap_d;
    logic       p1_acc_q, p1_acc_d, p2_acc_q, p2_acc_d;
    logic       check_done_q, check_done_d;
    logic       p1_win_q, p1_win_d, p2_win_q, p2_win_d;
    logic       error_q, error_d, draw_q, draw_d;

    logic [2:0] lidx;
    logic [8:0] lmask;
    logic       p1_hit, p2_hit, p1_any, p2_any;
    logic       err_new, win1_new, win2_new, draw_new;

    always_comb begin
        p1_hit = 1'b0;
        p2_hit = 1'b0;
        lidx   = idx_q;
        lmask  = '0;
        for (int unsigned k = 0; k < LINES_PER_CYCLE; k++) begin
            lidx  = idx_q + 3'(k);
            lmask = line_mask(lidx);
            if ((p1_snap_q & lmask) == lmask) p1_hit = 1'b1;
            if ((p2_snap_q & lmask) == lmask) p2_hit = 1'b1;
        end

        p1_any   = p1_acc_q | p1_hit;
        p2_any   = p2_acc_q | p2_hit;
        err_new  = (|(p1_snap_q & p2_snap_q)) | (p1_any & p2_any);
        win1_new = ~err_new & p1_any;
        win2_new = ~err_new & ~p1_any & p2_any;
`ifdef DRAW_DETECT_EN
        draw_new = ~err_new & ~p1_any & ~p2_any & (&(p1_snap_q | p2_snap_q));
`else
        draw_new = 1'b0;
`endif

        state_d      = state_q;
        idx_d        = idx_q;
        p1_snap_d    = p1_snap_q;
        p2_snap_d    = p2_snap_q;
        p1_acc_d     = p1_acc_q;
        p2_acc_d     = p2_acc_q;
        check_done_d = 1'b0;
        p1_win_d     = p1_win_q;
        p2_win_d     = p2_win_q;
        error_d      = error_q;
        draw_d       = draw_q;

        unique case (state_q)
            StIdle: begin
                if (bus.move_valid) begin
                    p1_snap_d = bus.p1_marks;
                    p2_snap_d = bus.p2_marks;
                    p1_acc_d  = 1'b0;
                    p2_acc_d  = 1'b0;
                    idx_d     = '0;
                    state_d   = StScan;
                end
            end
            StScan: begin
                p1_acc_d = p1_any;
                p2_acc_d = p2_any;
                idx_d    = idx_q + Step;
                if (idx_q == LastIdx) begin
                    check_done_d = 1'b1;
                    p1_win_d     = p1_win_q | win1_new;
                    p2_win_d     = p2_win_q | win2_new;
                    error_d      = error_q | err_new;
                    draw_d       = draw_q | draw_new;
                    state_d      = (win1_new | win2_new | err_new | draw_new) ? StOver : StIdle;
                end
            end
            StOver: ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            p1_snap_q    <= '0;
            p2_snap_q    <= '0;
            p1_acc_q     <= 1'b0;
            p2_acc_q     <= 1'b0;
            check_done_q <= 1'b0;
            p1_win_q     <= 1'b0;
            p2_win_q     <= 1'b0;
            error_q      <= 1'b0;
            draw_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            p1_snap_q    <= p1_snap_d;
            p2_snap_q    <= p2_snap_d;
            p1_acc_q     <= p1_acc_d;
            p2_acc_q     <= p2_acc_d;
            check_done_q <= check_done_d;
            p1_win_q     <= p1_win_d;
            p2_win_q     <= p2_win_d;
            error_q      <= error_d;
            draw_q       <= draw_d;
        end
    end

    assign bus.busy        = (state_q == StScan);
    assign bus.check_done  = check_done_q;
    assign bus.player1_win = p1_win_q;
    assign bus.player2_win = p2_win_q;
    assign bus.board_error = error_q;
    assign bus.draw        = draw_q;

endmodule

// File: tb/tb_win_checker.sv
// Bench for win_checker: LINES_PER_CYCLE=1 and =8 instances share stimulus and are compared
// every cycle against a transaction-level game model, plus hand-computed literal checks.
module tb_win_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       mv;
    logic [8:0] p1, p2;

    always #5 clk = ~clk;

    win_if if0 ();
    win_if if8 ();

    assign if0.move_valid = mv;
    assign if0.p1_marks   = p1;
    assign if0.p2_marks   = p2;
    assign if8.move_valid = mv;
    assign if8.p1_marks   = p1;
    assign if8.p2_marks   = p2;

    win_checker #(.LINES_PER_CYCLE(1)) dut1 (.clk(clk), .reset(reset), .bus(if0));
    win_checker #(.LINES_PER_CYCLE(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));

    // {busy, check_done, player1_win, player2_win, board_error, draw}
    logic [5:0] act [2];
    assign act[0] = {if0.busy, if0.check_done, if0.player1_win, if0.player2_win,
                     if0.board_error, if0.draw};
    assign act[1] = {if8.busy, if8.check_done, if8.player1_win, if8.player2_win,
                     if8.board_error, if8.draw};

    localparam int LINES [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                                    '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

    // Result of a finished check as {p1 win, p2 win, error, draw}.
    function automatic logic [3:0] judge(input logic [8:0] a, input logic [8:0] b);
        bit h1 = 0, h2 = 0, err, w1, w2, drw;
        for (int l = 0; l < 8; l++) begin
            if (a[LINES[l][0]] && a[LINES[l][1]] && a[LINES[l][2]]) h1 = 1;
            if (b[LINES[l][0]] && b[LINES[l][1]] && b[LINES[l][2]]) h2 = 1;
        end
        err = ((a & b) != 0) || (h1 && h2);
        w1  = !err && h1;
        w2  = !err && !h1 && h2;
        drw = 0;
`ifdef DRAW_DETECT_EN
        drw = !err && !h1 && !h2 && ((a | b) == 9'h1FF);
`endif
        return {w1, w2, err, drw};
    endfunction

    function automatic int scan_len(input int i);
        return (i == 0) ? 8 : 1;
    endfunction

    int         m_cnt   [2] = '{0, 0};
    logic       m_over  [2] = '{1'b0, 1'b0};
    logic       m_done  [2] = '{1'b0, 1'b0};
    logic [3:0] m_flags [2] = '{4'h0, 4'h0};
    logic [3:0] m_res   [2] = '{4'h0, 4'h0};

    // Model: a check occupies the checker for scan_len cycles, then publishes its verdict.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_cnt[i]   <= 0;
                m_over[i]  <= 1'b0;
                m_done[i]  <= 1'b0;
                m_flags[i] <= 4'h0;
            end else begin
                m_done[i] <= 1'b0;
                if (m_cnt[i] != 0) begin
                    m_cnt[i] <= m_cnt[i] - 1;
                    if (m_cnt[i] == 1) begin
                        m_done[i]  <= 1'b1;
                        m_flags[i] <= m_flags[i] | m_res[i];
                        if (m_res[i] != 0) m_over[i] <= 1'b1;
                    end
                end else if (!m_over[i] && mv) begin
                    m_cnt[i] <= scan_len(i);
                    m_res[i] <= judge(p1, p2);
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [5:0] exp_v;
                exp_v = {m_cnt[i] != 0, m_done[i], m_flags[i]};
                n_tests++;
                if (act[i] !== exp_v) begin
                    n_fail++;
                    $display("FAIL model_cmp inst%0d t=%0t: got %b expected %b", i, $time,
                             act[i], exp_v);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp_v);
        n_tests++;
        if (got != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mv    = 1'b0;
        step();
        reset = 1'b1;
    endtask

    // Pulse (or hold) move_valid, then watch `cycles` negedges; k=0 is the cycle after the
    // sampling edge. Optional extra move pulse and reset pulse at given k.
    task automatic run_move(input logic [8:0] a, input logic [8:0] b, input int cycles,
                            input bit hold, input int extra_k, input int rst_k,
                            output int lat0, output int lat1, output int cnt0,
                            output int cnt1, output int snap0);
        p1 = a;
        p2 = b;
        mv = 1'b1;
        step();
        if (!hold) mv = 1'b0;
        lat0 = -1; lat1 = -1; cnt0 = 0; cnt1 = 0; snap0 = -1;
        for (int k = 0; k < cycles; k++) begin
            if (k > 0) step();
            if (if0.check_done) begin cnt0++; if (lat0 < 0) lat0 = k; end
            if (if8.check_done) begin cnt1++; if (lat1 < 0) lat1 = k; end
            if (k == rst_k + 1) snap0 = int'(act[0]);
            mv    = hold || (k == extra_k);
            reset = (k != rst_k);
        end
        mv    = 1'b0;
        reset = 1'b1;
    endtask

    logic [8:0] tbl_p1 [4] = '{9'h1C0, 9'h049, 9'h124, 9'h000};
    logic [8:0] tbl_p2 [4] = '{9'h003, 9'h092, 9'h000, 9'h000};

    initial begin
        int l0, l1, c0, c1, s0;
        reset = 1'b0; mv = 1'b0; p1 = '0; p2 = '0;
        step();
        step();
        reset  = 1'b1;
        chk_en = 1'b1;
        check("reset_out_lpc1", int'(act[0]), 0);
        check("reset_out_lpc8", int'(act[1]), 0);

        run_move(9'h007, 9'h030, 12, 0, -1, -1, l0, l1, c0, c1, s0);
        check("p1row_latency_lpc1", l0, 8);
        check("p1row_latency_lpc8", l1, 1);
        check("p1row_done_count", c0, 1);
        check("p1row_p1win", int'(if0.player1_win), 1);
        check("p1row_others", int'({if0.player2_win, if0.board_error, if0.draw}), 0);

        do_reset();
        run_move(9'h00A, 9'h111, 12, 0, -1, -1, l0, l1, c0, c1, s0);
        check("p2diag_p2win", int'(if0.player2_win), 1);
        check("p2diag_p1win", int'(if0.player1_win), 0);
        run_move(9'h038, 9'h000, 12, 0, -1, -1, l0, l1, c0, c1, s0);
        check("over_ignores_move_lpc1", c0, 0);
        check("over_ignores_move_lpc8", c1, 0);

        do_reset();
        run_move(9'h001, 9'h001, 12, 0, -1, -1, l0, l1, c0, c1, s0);
        check("overlap_error", int'(if0.board_error), 1);
        check("overlap_no_wins", int'({if0.player1_win, if0.player2_win}), 0);

        do_reset();
        run_move(9'h18D, 9'h072, 12, 0, -1, -1, l0, l1, c0, c1, s0);
        check("full_no_wins", int'({if0.player1_win, if0.player2_win}), 0);
`ifdef DRAW_DETECT_EN
        check("full_draw", int'(if0.draw), 1);
        run_move(9'h007, 9'h000, 12, 0, -1, -1, l0, l1, c0, c1, s0);
        check("draw_over_ignores", c0, 0);
`else
        check("full_draw_tied0", int'(if0.draw), 0);
        run_move(9'h007, 9'h000, 12, 0, -1, -1, l0, l1, c0, c1, s0);
        check("full_back_to_idle", c0, 1);
`endif

        do_reset();
        run_move(9'h007, 9'h030, 12, 0, -1, 3, l0, l1, c0, c1, s0);
        check("midscan_reset_outputs", s0, 0);
        check("midscan_reset_no_done", c0, 0);
        run_move(9'h038, 9'h000, 12, 0, -1, -1, l0, l1, c0, c1, s0);
        check("after_reset_latency", l0, 8);
        check("after_reset_p1win", int'(if0.player1_win), 1);

        do_reset();
        run_move(9'h054, 9'h000, 14, 0, 3, -1, l0, l1, c0, c1, s0);
        check("anti_lpc8_latency", l1, 1);
        check("anti_lpc8_p1win", int'(if8.player1_win), 1);
        check("busy_move_ignored_count", c0, 1);
        check("busy_move_ignored_latency", l0, 8);

        do_reset();
        run_move(9'h001, 9'h002, 20, 1, -1, -1, l0, l1, c0, c1, s0);
        check("back_to_back_lpc1", c0, 2);
        check("back_to_back_lpc8", c1, 10);

        for (int t = 0; t < 4; t++) begin
            do_reset();
            run_move(tbl_p1[t], tbl_p2[t], 12, 0, -1, -1, l0, l1, c0, c1, s0);
        end
        check("both_lines_error", int'(if0.board_error), 0);

        do_reset();
        run_move(9'h049, 9'h092, 12, 0, -1, -1, l0, l1, c0, c1, s0);
        check("both_players_line_error", int'(if0.board_error), 1);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
